// File: rtl/mem_loader.sv
// Boot loader: collects UART bytes into little-endian words, writes them to RAM,
// then hands the RAM port to the CPU as a combinational pass-through.
//
// state   | meaning
// --------+-----------------------------------------------------------
// INIT    | reset state, bus idle
// COLLECT | accepting bytes into the assembly buffer
// WRITE   | holding a RAM write until ram_mem_ready is sampled
// GAP     | one idle cycle that swallows the controller's trailing ready
// DONE    | CPU owns the RAM port, CPU reset released
module mem_loader #(
    parameter int unsigned LOAD_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [3:0]  cpu_mem_wstrb,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [31:0] cpu_mem_addr,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        ram_mem_valid,
    output logic        ram_mem_instr,
    output logic [3:0]  ram_mem_wstrb,
    output logic [31:0] ram_mem_wdata,
    output logic [31:0] ram_mem_addr,
    input  logic        ram_mem_ready,
    input  logic [31:0] ram_mem_rdata,
    output logic        cpu_resetn,
    output logic        done
);

    localparam int CW = (LOAD_WORDS == 0) ? 1 : $clog2(LOAD_WORDS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(LOAD_WORDS);

    typedef enum logic [2:0] {
        S_INIT,
        S_COLLECT,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    byte_idx;
    logic [CW-1:0] word_count;
    logic [31:0]   word_buf;
    logic [31:0]   write_addr;
    logic          accept;

    assign accept     = (state == S_COLLECT) && rx_valid;
    // Address wraps modulo 2^32 by construction of the 32-bit sum.
    assign write_addr = BASE_ADDR + (32'(word_count) << 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            byte_idx   <= 2'd0;
            word_count <= '0;
            word_buf   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                byte_idx                          <= byte_idx + 2'd1;
            end
            if ((state == S_WRITE) && ram_mem_ready) begin
                word_count <= word_count + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rx_ready      = 1'b0;
        ram_mem_valid = 1'b0;
        ram_mem_instr = 1'b0;
        ram_mem_wstrb = 4'h0;
        ram_mem_wdata = 32'd0;
        ram_mem_addr  = 32'd0;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = 32'd0;
        cpu_resetn    = 1'b0;
        done          = 1'b0;

        case (state)
            S_INIT: begin
                state_nxt = (LOAD_WORDS == 0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                rx_ready = 1'b1;
                if (rx_valid && (byte_idx == 2'd3)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_mem_valid = 1'b1;
                ram_mem_wstrb = 4'hF;
                ram_mem_wdata = word_buf;
                ram_mem_addr  = write_addr;
                if (ram_mem_ready) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = (word_count == LAST_COUNT) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                ram_mem_valid = cpu_mem_valid;
                ram_mem_instr = cpu_mem_instr;
                ram_mem_wstrb = cpu_mem_wstrb;
                ram_mem_wdata = cpu_mem_wdata;
                ram_mem_addr  = cpu_mem_addr;
                cpu_mem_ready = ram_mem_ready;
                cpu_mem_rdata = ram_mem_rdata;
                cpu_resetn    = 1'b1;
                done          = 1'b1;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected RAM writes are queued as bytes are
// driven and matched against the write handshakes seen on the RAM port.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_mem_valid;
    logic        cpu_mem_instr;
    logic [3:0]  cpu_mem_wstrb;
    logic [31:0] cpu_mem_wdata;
    logic [31:0] cpu_mem_addr;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        ram_mem_valid;
    logic        ram_mem_instr;
    logic [3:0]  ram_mem_wstrb;
    logic [31:0] ram_mem_wdata;
    logic [31:0] ram_mem_addr;
    logic        ram_mem_ready;
    logic [31:0] ram_mem_rdata;
    logic        cpu_resetn;
    logic        done;

    logic        reset0;
    logic        rx_ready0;
    logic        cpu_mem_ready0;
    logic [31:0] cpu_mem_rdata0;
    logic        ram_mem_valid0;
    logic        ram_mem_instr0;
    logic [3:0]  ram_mem_wstrb0;
    logic [31:0] ram_mem_wdata0;
    logic [31:0] ram_mem_addr0;
    logic        cpu_resetn0;
    logic        done0;

    localparam logic [31:0] BASE = 32'h0000_0000;

    always #5 clk = ~clk;

    mem_loader #(.LOAD_WORDS(2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .ram_mem_valid(ram_mem_valid), .ram_mem_instr(ram_mem_instr),
        .ram_mem_wstrb(ram_mem_wstrb), .ram_mem_wdata(ram_mem_wdata),
        .ram_mem_addr(ram_mem_addr), .ram_mem_ready(ram_mem_ready),
        .ram_mem_rdata(ram_mem_rdata),
        .cpu_resetn(cpu_resetn), .done(done)
    );

    mem_loader #(.LOAD_WORDS(0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .reset(reset0),
        .rx_data(8'h5A), .rx_valid(1'b1), .rx_ready(rx_ready0),
        .cpu_mem_valid(1'b0), .cpu_mem_instr(1'b0),
        .cpu_mem_wstrb(4'h0), .cpu_mem_wdata(32'd0),
        .cpu_mem_addr(32'd0), .cpu_mem_ready(cpu_mem_ready0),
        .cpu_mem_rdata(cpu_mem_rdata0),
        .ram_mem_valid(ram_mem_valid0), .ram_mem_instr(ram_mem_instr0),
        .ram_mem_wstrb(ram_mem_wstrb0), .ram_mem_wdata(ram_mem_wdata0),
        .ram_mem_addr(ram_mem_addr0), .ram_mem_ready(1'b0),
        .ram_mem_rdata(32'd0),
        .cpu_resetn(cpu_resetn0), .done(done0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory controller model: registered ready that trails valid by one cycle.
    logic [31:0] mem [64];
    logic        ready_q = 1'b0;
    logic        hold_ready = 1'b0;

    assign ram_mem_ready = ready_q;
    assign ram_mem_rdata = mem[ram_mem_addr[7:2]];

    initial for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    always @(posedge clk) begin
        ready_q <= ram_mem_valid && !hold_ready;
        if (ram_mem_valid && ready_q) begin
            for (int b = 0; b < 4; b++)
                if (ram_mem_wstrb[b]) mem[ram_mem_addr[7:2]][8*b +: 8] <= ram_mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  widx = 0;
    int  acc_cnt = 0;
    logic rx0_seen = 1'b0;

    always @(negedge clk) begin
        if (!reset && rx_valid && rx_ready) acc_cnt++;
        if (rx_ready0) rx0_seen = 1'b1;
        if (!reset && !done && ram_mem_valid && ram_mem_ready) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", ram_mem_addr, e.addr);
                chk("wr_data", ram_mem_wdata, e.data);
                chk("wr_wstrb", 32'(ram_mem_wstrb), 32'hF);
                chk("wr_instr", 32'(ram_mem_instr), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        hold_ready = 1'b0;
        widx = 0;
        repeat (2) @(negedge clk);
        acc_cnt = 0;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_ram_valid", 32'(ram_mem_valid), 32'd0);
        chk("rst_ram_wstrb", 32'(ram_mem_wstrb), 32'd0);
        chk("rst_ram_addr", ram_mem_addr, 32'd0);
        chk("rst_ram_wdata", ram_mem_wdata, 32'd0);
        chk("rst_ram_instr", 32'(ram_mem_instr), 32'd0);
        chk("rst_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_mem_rdata, 32'd0);
        chk("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        #1;
        chk("init_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        chk("collect_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int n;
        int g;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        @(negedge clk);
        if (g > 0) begin
            rx_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        rx_data = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        wr_t e;
        e.addr = BASE + 32'(widx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        widx++;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gapmax);
    endtask

    // Waits for the final write handshake, then checks GAP and the first DONE cycle.
    task automatic finish_load(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(ram_mem_valid && ram_mem_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_write_seen"}, 32'(ram_mem_valid && ram_mem_ready), 32'd1);
        @(negedge clk);
        chk({tag, "_gap_done"}, 32'(done), 32'd0);
        chk({tag, "_gap_valid"}, 32'(ram_mem_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'd1);
        chk({tag, "_done_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_cpu_ready(input string tag);
        int n;
        n = 0;
        while (!cpu_mem_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cpu_mem_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        reset0 = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        // CPU requests a read while loading; it must never reach the RAM port.
        cpu_mem_valid = 1'b1;
        cpu_mem_instr = 1'b1;
        cpu_mem_wstrb = 4'h0;
        cpu_mem_wdata = 32'hBADB_AD00;
        cpu_mem_addr  = 32'h0000_003C;

        // LOAD_WORDS = 0 instance
        repeat (2) @(negedge clk);
        chk("lw0_rst_done", 32'(done0), 32'd0);
        reset0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("lw0_done", 32'(done0), 32'd1);
        chk("lw0_cpu_resetn", 32'(cpu_resetn0), 32'd1);

        // Back-to-back load
        do_reset();
        send_word(32'h4433_2211, 0);
        send_word(32'h8877_6655, 0);
        finish_load("b2b");
        chk("b2b_accepted", 32'(acc_cnt), 32'd8);

        // Random gaps on rx_valid
        do_reset();
        send_word(32'h4433_2211, 3);
        send_word(32'h8877_6655, 3);
        finish_load("gaps");
        chk("gaps_accepted", 32'(acc_cnt), 32'd8);

        // Controller stalls ready for 5 cycles in WRITE
        do_reset();
        hold_ready = 1'b1;
        send_word(32'h1234_5678, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(ram_mem_valid), 32'd1);
            chk("stall_addr", ram_mem_addr, BASE);
            chk("stall_data", ram_mem_wdata, 32'h1234_5678);
            chk("stall_rx_ready", 32'(rx_ready), 32'd0);
            chk("stall_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        end
        hold_ready = 1'b0;
        send_word(32'h9ABC_DEF0, 0);
        finish_load("stall");

        // Reset after 6 bytes, then reload from BASE
        do_reset();
        send_word(32'h4433_2211, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        chk("partial_queue_empty", 32'(exp_q.size()), 32'd0);
        do_reset();
        send_word(32'hADAC_ABAA, 0);
        send_word(32'hB1B0_AFAE, 0);
        finish_load("reload");
        chk("reload_mem0", mem[0], 32'hADAC_ABAA);
        chk("reload_mem1", mem[1], 32'hB1B0_AFAE);

        // Pass-through: partial CPU write then read back
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_instr = 1'b0;
        cpu_mem_wstrb = 4'h3;
        cpu_mem_addr  = 32'h0000_0010;
        cpu_mem_wdata = 32'hDEAD_BEEF;
        #1;
        chk("pt_valid", 32'(ram_mem_valid), 32'd1);
        chk("pt_addr", ram_mem_addr, 32'h0000_0010);
        chk("pt_wdata", ram_mem_wdata, 32'hDEAD_BEEF);
        chk("pt_wstrb", 32'(ram_mem_wstrb), 32'h3);
        chk("pt_instr", 32'(ram_mem_instr), 32'd0);
        chk("pt_ready", 32'(cpu_mem_ready), 32'(ram_mem_ready));
        wait_cpu_ready("pt_write_ready");
        @(negedge clk);
        cpu_mem_valid = 1'b0;
        #1;
        chk("pt_valid_low", 32'(ram_mem_valid), 32'd0);
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_instr = 1'b1;
        cpu_mem_wstrb = 4'h0;
        #1;
        chk("pt_rd_instr", 32'(ram_mem_instr), 32'd1);
        chk("pt_rd_wstrb", 32'(ram_mem_wstrb), 32'h0);
        wait_cpu_ready("pt_read_ready");
        chk("pt_rdata", cpu_mem_rdata, 32'hC0DE_BEEF);
        @(negedge clk);
        cpu_mem_valid = 1'b0;

        chk("lw0_rx_ready_never", 32'(rx0_seen), 32'd0);
        chk("lw0_still_done", 32'(done0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
